// File: rtl/rggen_axi4lite_bridge.sv
// Register-bus to AXI4-Lite master bridge: carries one host request at a time as a
// single AXI4-Lite read or write, then hands the response back to the host.
module rggen_axi4lite_bridge #(
  parameter int        ID_WIDTH      = 0,
  parameter bit [31:0] ID            = '0,
  parameter int        ADDRESS_WIDTH = 8,
  parameter int        BUS_WIDTH     = 32,
  localparam int       IDW           = (ID_WIDTH > 0) ? ID_WIDTH : 1,
  localparam int       STRB_WIDTH    = BUS_WIDTH / 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  // register bus (host side)
  input  logic                     i_bus_valid,
  input  logic [1:0]               i_bus_access,
  input  logic [ADDRESS_WIDTH-1:0] i_bus_address,
  input  logic [BUS_WIDTH-1:0]     i_bus_write_data,
  input  logic [STRB_WIDTH-1:0]    i_bus_strobe,
  output logic                     o_bus_ready,
  output logic [1:0]               o_bus_status,
  output logic [BUS_WIDTH-1:0]     o_bus_read_data,
  // AXI4-Lite master
  output logic                     o_axi_awvalid,
  input  logic                     i_axi_awready,
  output logic [IDW-1:0]           o_axi_awid,
  output logic [ADDRESS_WIDTH-1:0] o_axi_awaddr,
  output logic [2:0]               o_axi_awprot,
  output logic                     o_axi_wvalid,
  input  logic                     i_axi_wready,
  output logic [BUS_WIDTH-1:0]     o_axi_wdata,
  output logic [STRB_WIDTH-1:0]    o_axi_wstrb,
  input  logic                     i_axi_bvalid,
  output logic                     o_axi_bready,
  input  logic [IDW-1:0]           i_axi_bid,
  input  logic [1:0]               i_axi_bresp,
  output logic                     o_axi_arvalid,
  input  logic                     i_axi_arready,
  output logic [IDW-1:0]           o_axi_arid,
  output logic [ADDRESS_WIDTH-1:0] o_axi_araddr,
  output logic [2:0]               o_axi_arprot,
  input  logic                     i_axi_rvalid,
  output logic                     o_axi_rready,
  input  logic [IDW-1:0]           i_axi_rid,
  input  logic [1:0]               i_axi_rresp,
  input  logic [BUS_WIDTH-1:0]     i_axi_rdata
);

  localparam int         ACCESS_DATA_BIT = 0;
  localparam logic [1:0] STATUS_OKAY     = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    ADDRESS,
    RESPONSE
  } state_e;

  state_e                   state_q, state_d;
  logic [1:0]               access_q, access_d;
  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic [BUS_WIDTH-1:0]     write_data_q, write_data_d;
  logic [STRB_WIDTH-1:0]    strobe_q, strobe_d;
  logic                     aw_done_q, aw_done_d;
  logic                     w_done_q, w_done_d;
  logic                     awvalid_q, awvalid_d;
  logic                     wvalid_q, wvalid_d;
  logic                     arvalid_q, arvalid_d;
  logic                     bready_q, bready_d;
  logic                     rready_q, rready_d;

  logic is_write;
  logic b_fire;
  logic r_fire;

  assign is_write = access_q[ACCESS_DATA_BIT];
  assign b_fire   = bready_q & i_axi_bvalid;
  assign r_fire   = rready_q & i_axi_rvalid;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    access_d     = access_q;
    address_d    = address_q;
    write_data_d = write_data_q;
    strobe_d     = strobe_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    arvalid_d    = arvalid_q;
    bready_d     = bready_q;
    rready_d     = rready_q;

    case (state_q)
      IDLE: begin
        if (i_bus_valid) begin
          access_d     = i_bus_access;
          address_d    = i_bus_address;
          write_data_d = i_bus_write_data;
          strobe_d     = i_bus_strobe;
          aw_done_d    = 1'b0;
          w_done_d     = 1'b0;
          awvalid_d    = i_bus_access[ACCESS_DATA_BIT];
          wvalid_d     = i_bus_access[ACCESS_DATA_BIT];
          arvalid_d    = !i_bus_access[ACCESS_DATA_BIT];
          state_d      = ADDRESS;
        end
      end
      ADDRESS: begin
        if (is_write) begin
          // AW and W finish independently; leave once both are done.
          aw_done_d = aw_done_q | (awvalid_q & i_axi_awready);
          w_done_d  = w_done_q  | (wvalid_q  & i_axi_wready);
          awvalid_d = awvalid_q & !i_axi_awready;
          wvalid_d  = wvalid_q  & !i_axi_wready;
          if (aw_done_d && w_done_d) begin
            bready_d = 1'b1;
            state_d  = RESPONSE;
          end
        end else if (arvalid_q && i_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RESPONSE;
        end
      end
      RESPONSE: begin
        if (b_fire || r_fire) begin
          bready_d = 1'b0;
          rready_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      access_q  <= '0;
      address_q <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      access_q  <= access_d;
      address_q <= address_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
    end
  end

  // NOTE: the data payload is qualified by wvalid, so it needs no reset and is
  // kept out of the reset tree.
  always_ff @(posedge i_clk) begin
    write_data_q <= write_data_d;
    strobe_q     <= strobe_d;
  end

  assign o_axi_awvalid = awvalid_q;
  assign o_axi_awid    = ID[IDW-1:0];
  assign o_axi_awaddr  = address_q;
  assign o_axi_awprot  = 3'b000;
  assign o_axi_wvalid  = wvalid_q;
  assign o_axi_wdata   = write_data_q;
  assign o_axi_wstrb   = strobe_q;
  assign o_axi_bready  = bready_q;
  assign o_axi_arvalid = arvalid_q;
  assign o_axi_arid    = ID[IDW-1:0];
  assign o_axi_araddr  = address_q;
  assign o_axi_arprot  = 3'b000;
  assign o_axi_rready  = rready_q;

  // AXI resp and register-bus status share one encoding, so pass it straight through.
  assign o_bus_ready     = b_fire | r_fire;
  assign o_bus_status    = b_fire ? i_axi_bresp : (r_fire ? i_axi_rresp : STATUS_OKAY);
  assign o_bus_read_data = r_fire ? i_axi_rdata : '0;

  logic unused_inputs;
  assign unused_inputs = ^{i_axi_bid, i_axi_rid, access_q[1]};

endmodule

// File: tb/tb_rggen_axi4lite_bridge.sv
// Bench for rggen_axi4lite_bridge: directed and random transactions against a
// cycle-timeline model of the bridge built from its latency and handshake rules.
module tb_rggen_axi4lite_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bus_valid;
  logic [1:0]  bus_access;
  logic [7:0]  bus_address;
  logic [31:0] bus_write_data;
  logic [3:0]  bus_strobe;
  logic        bus_ready;
  logic [1:0]  bus_status;
  logic [31:0] bus_read_data;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [0:0]  awid, arid, bid, rid;
  logic [7:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rggen_axi4lite_bridge dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_bus_valid     (bus_valid),
    .i_bus_access    (bus_access),
    .i_bus_address   (bus_address),
    .i_bus_write_data(bus_write_data),
    .i_bus_strobe    (bus_strobe),
    .o_bus_ready     (bus_ready),
    .o_bus_status    (bus_status),
    .o_bus_read_data (bus_read_data),
    .o_axi_awvalid   (awvalid),
    .i_axi_awready   (awready),
    .o_axi_awid      (awid),
    .o_axi_awaddr    (awaddr),
    .o_axi_awprot    (awprot),
    .o_axi_wvalid    (wvalid),
    .i_axi_wready    (wready),
    .o_axi_wdata     (wdata),
    .o_axi_wstrb     (wstrb),
    .i_axi_bvalid    (bvalid),
    .o_axi_bready    (bready),
    .i_axi_bid       (bid),
    .i_axi_bresp     (bresp),
    .o_axi_arvalid   (arvalid),
    .i_axi_arready   (arready),
    .o_axi_arid      (arid),
    .o_axi_araddr    (araddr),
    .o_axi_arprot    (arprot),
    .i_axi_rvalid    (rvalid),
    .o_axi_rready    (rready),
    .i_axi_rid       (rid),
    .i_axi_rresp     (rresp),
    .i_axi_rdata     (rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = '0;
    arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = '0;  rid = '0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, ".awvalid"}, awvalid, 0);
    chk({tag, ".wvalid"},  wvalid,  0);
    chk({tag, ".arvalid"}, arvalid, 0);
    chk({tag, ".bready"},  bready,  0);
    chk({tag, ".rready"},  rready,  0);
    chk({tag, ".ready"},   bus_ready, 0);
    chk({tag, ".status"},  bus_status, 0);
    chk({tag, ".rdata"},   bus_read_data, 0);
  endtask

  // One host request against a slave whose ready/valid timing is given in cycles.
  // Cycle 0 is the IDLE cycle in which the request is presented; entry/exit is 1
  // time unit after a rising edge.
  task automatic run_txn(input string tag, input bit wr, input logic [1:0] acc,
                         input logic [7:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int a_wait, input int w_wait,
                         input int resp_start, input logic [1:0] resp,
                         input logic [31:0] rd, input bit hold_after);
    int a_hs, w_hs, addr_end, rdy;
    int aw_beats, w_beats, ar_beats, readies;
    a_hs     = 1 + a_wait;
    w_hs     = 1 + w_wait;
    addr_end = wr ? ((a_hs > w_hs) ? a_hs : w_hs) : a_hs;
    rdy      = (addr_end + 1 > resp_start) ? addr_end + 1 : resp_start;
    aw_beats = 0; w_beats = 0; ar_beats = 0; readies = 0;

    bus_valid      = 1'b1;
    bus_access     = acc;
    bus_address    = addr;
    bus_write_data = data;
    bus_strobe     = strb;
    for (int c = 0; c <= rdy; c++) begin
      awready = wr  && (c >= a_hs);
      wready  = wr  && (c >= w_hs);
      arready = !wr && (c >= a_hs);
      bvalid  = wr  && (c >= resp_start);
      rvalid  = !wr && (c >= resp_start);
      bresp   = wr  ? resp : $urandom_range(0, 3);
      rresp   = !wr ? resp : $urandom_range(0, 3);
      rdata   = !wr ? rd : $urandom;
      #1;
      chk({tag, ".awvalid"}, awvalid, wr  && c >= 1 && c <= a_hs);
      chk({tag, ".wvalid"},  wvalid,  wr  && c >= 1 && c <= w_hs);
      chk({tag, ".arvalid"}, arvalid, !wr && c >= 1 && c <= a_hs);
      chk({tag, ".bready"},  bready,  wr  && c > addr_end);
      chk({tag, ".rready"},  rready,  !wr && c > addr_end);
      chk({tag, ".ready"},   bus_ready, c == rdy);
      chk({tag, ".status"},  bus_status, (c == rdy) ? resp : 2'b00);
      chk({tag, ".rdata"},   bus_read_data, (c == rdy && !wr) ? rd : 32'h0);
      if (awvalid) begin
        chk({tag, ".awaddr"}, awaddr, addr);
        chk({tag, ".awprot"}, awprot, 0);
        chk({tag, ".awid"},   awid,   0);
      end
      if (wvalid) begin
        chk({tag, ".wdata"}, wdata, data);
        chk({tag, ".wstrb"}, wstrb, strb);
      end
      if (arvalid) begin
        chk({tag, ".araddr"}, araddr, addr);
        chk({tag, ".arprot"}, arprot, 0);
        chk({tag, ".arid"},   arid,   0);
      end
      if (awvalid && awready) aw_beats++;
      if (wvalid && wready)   w_beats++;
      if (arvalid && arready) ar_beats++;
      if (bus_ready)          readies++;
      @(posedge clk);
      #1;
    end
    slave_idle();
    if (!hold_after) bus_valid = 1'b0;
    chk({tag, ".aw_beats"}, aw_beats, wr ? 1 : 0);
    chk({tag, ".w_beats"},  w_beats,  wr ? 1 : 0);
    chk({tag, ".ar_beats"}, ar_beats, wr ? 0 : 1);
    chk({tag, ".readies"},  readies,  1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bus_valid      = 1'b0;
    bus_access     = 2'b00;
    bus_address    = '0;
    bus_write_data = '0;
    bus_strobe     = '0;
    slave_idle();
    #2;
    check_quiet("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    #1;
    check_quiet("post_reset");
    @(posedge clk); #1;

    // Zero-wait write, then a read whose slave waits 3 cycles with SLVERR.
    run_txn("wr_zero_wait", 1, 2'b11, 8'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 32'h0, 0);
    run_txn("rd_slverr", 0, 2'b10, 8'h24, 32'h0, 4'h0, 0, 0, 5, 2'b10, 32'h12345678, 0);
    // W accepted two cycles before AW.
    run_txn("wr_w_first", 1, 2'b11, 8'h44, 32'hA5A5_0F0F, 4'h5, 2, 0, 0, 2'b00, 32'h0, 0);
    // bvalid raised while AW still pending.
    run_txn("wr_early_b", 1, 2'b01, 8'h48, 32'h0BAD_F00D, 4'h3, 2, 0, 1, 2'b11, 32'h0, 0);
    // Back-to-back with valid held: read starts in the IDLE cycle after ready.
    run_txn("b2b_wr", 1, 2'b11, 8'h00, 32'h1111_2222, 4'hF, 0, 0, 0, 2'b00, 32'h0, 1);
    run_txn("b2b_rd", 0, 2'b10, 8'h04, 32'h0, 4'h0, 0, 0, 0, 2'b01, 32'hCAFE_0004, 0);

    // Reset during ADDRESS: outputs drop at once, then a read completes normally.
    bus_valid      = 1'b1;
    bus_access     = 2'b11;
    bus_address    = 8'h30;
    bus_write_data = 32'h3030_3030;
    bus_strobe     = 4'hF;
    @(posedge clk); #1;
    #1;
    chk("rst_mid.awvalid_before", awvalid, 1);
    chk("rst_mid.wvalid_before",  wvalid,  1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.awvalid_async", awvalid, 0);
    chk("rst_mid.wvalid_async",  wvalid,  0);
    chk("rst_mid.ready_async",   bus_ready, 0);
    bus_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    #1;
    check_quiet("rst_mid.idle");
    @(posedge clk); #1;
    run_txn("rst_mid.read", 0, 2'b10, 8'h34, 32'h0, 4'h0, 1, 0, 0, 2'b00, 32'h7777_8888, 0);

    // Random traffic: random direction, payload, wait states and response timing.
    for (int n = 0; n < 40; n++) begin
      bit          wr;
      int          aw, ww, ae, rs;
      logic [1:0]  acc;
      wr  = 1'($urandom_range(0, 1));
      acc = wr ? ($urandom_range(0, 1) ? 2'b11 : 2'b01) : ($urandom_range(0, 1) ? 2'b10 : 2'b00);
      aw  = $urandom_range(0, 3);
      ww  = $urandom_range(0, 3);
      ae  = wr ? 1 + ((aw > ww) ? aw : ww) : 1 + aw;
      rs  = $urandom_range(0, ae + 3);
      run_txn($sformatf("rand%0d", n), wr, acc, 8'($urandom), $urandom, 4'($urandom),
              aw, ww, rs, 2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)));
    end
    bus_valid = 1'b0;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
